bfu_pair_feeder: RTL

- Streaming front end for one radix-2 FFT stage. Accepts one complex sample per valid cycle and presents sample pairs (x[k], x[k+SPAN]) to the butterfly unit's in_a/in_b inputs, together with a twiddle ROM address.
- Sits directly upstream of the butterfly unit. A per-stage instance uses SPAN = N/2, N/4, and so on.
- Sample format is {im[31:16], re[15:0]}, signed Q1.15, passed through unmodified.

---
 rtl/bfu_pair_feeder.sv | 103 ++++++++++
 1 files changed

// File: rtl/bfu_pair_feeder.sv
// Radix-2 FFT stage front end: buffers the first SPAN samples of each frame and
// emits (x[k], x[k+SPAN]) pairs with a twiddle ROM address to the butterfly unit.
module bfu_pair_feeder #(
   parameter int unsigned SPAN      = 8,
   parameter int unsigned IDX_W     = 3,
   parameter int unsigned TW_W      = 4,
   parameter int unsigned TW_STRIDE = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic            in_sync,
   input  logic [31:0]     in_data,
   output logic            out_valid,
   output logic [31:0]     out_a,
   output logic [31:0]     out_b,
   output logic [TW_W-1:0] tw_addr,
   output logic            out_first,
   output logic            sync_err
);

   localparam int unsigned     PROD_W   = IDX_W + TW_W;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SPAN - 1);

   typedef enum logic {
      FILL = 1'b0,
      PAIR = 1'b1
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [31:0]      pair_buf [SPAN];

   logic             idx_last_c;
   logic [IDX_W-1:0] idx_inc_c;
   logic             wr_en_c;
   logic [IDX_W-1:0] wr_addr_c;
   logic [PROD_W-1:0] tw_prod_c;

   assign idx_last_c = (idx == IDX_LAST);
   assign idx_inc_c  = idx_last_c ? '0 : idx + IDX_W'(1);
   assign tw_prod_c  = PROD_W'(idx) * PROD_W'(TW_STRIDE);

   // A sync sample always lands in slot 0, whatever the current state.
   assign wr_en_c   = in_valid && (in_sync || (state == FILL));
   assign wr_addr_c = in_sync ? '0 : idx;

   // Sample buffer; contents need no reset.
   always_ff @(posedge clk) begin
      if (wr_en_c) begin
         pair_buf[wr_addr_c] <= in_data;
      end
   end

   // Frame sequencer with registered pair outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= FILL;
         idx       <= '0;
         out_valid <= 1'b0;
         out_first <= 1'b0;
         sync_err  <= 1'b0;
         out_a     <= '0;
         out_b     <= '0;
         tw_addr   <= '0;
      end else begin
         out_valid <= 1'b0;
         sync_err  <= 1'b0;
         if (in_valid) begin
            if (in_sync) begin
               state    <= FILL;
               idx      <= IDX_W'(1);
               sync_err <= (state != FILL) || (idx != '0);
            end else begin
               unique case (state)
                  FILL: begin
                     idx <= idx_inc_c;
                     if (idx_last_c) begin
                        state <= PAIR;
                     end
                  end
                  PAIR: begin
                     out_a     <= pair_buf[idx];
                     out_b     <= in_data;
                     tw_addr   <= TW_W'(tw_prod_c);
                     out_valid <= 1'b1;
                     out_first <= (idx == '0);
                     idx       <= idx_inc_c;
                     if (idx_last_c) begin
                        state <= FILL;
                     end
                  end
                  default: begin
                     state <= FILL;
                     idx   <= '0;
                  end
               endcase
            end
         end
      end
   end

endmodule
